// File: rtl/redmule_tile_sched.sv
// Tile-iteration scheduler: walks M/N/K tile loops, issues X/W/Z descriptors and bounds in-flight Z stores.
// Optional stall-cycle counter is built when REDMULE_TILE_SCHED_PERF_EN is defined.
module redmule_tile_sched #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  m_tiles_i,
  input  logic [CNT_W-1:0]  n_tiles_i,
  input  logic [CNT_W-1:0]  k_tiles_i,
  input  logic [ADDR_W-1:0] x_base_i,
  input  logic [ADDR_W-1:0] w_base_i,
  input  logic [ADDR_W-1:0] z_base_i,
  input  logic [ADDR_W-1:0] x_m_stride_i,
  input  logic [ADDR_W-1:0] x_k_stride_i,
  input  logic [ADDR_W-1:0] w_k_stride_i,
  input  logic [ADDR_W-1:0] w_n_stride_i,
  input  logic [ADDR_W-1:0] z_m_stride_i,
  input  logic [ADDR_W-1:0] z_n_stride_i,
  output logic              tile_valid_o,
  input  logic              tile_ready_i,
  output logic [CNT_W-1:0]  tile_m_o,
  output logic [CNT_W-1:0]  tile_n_o,
  output logic [CNT_W-1:0]  tile_k_o,
  output logic [ADDR_W-1:0] x_addr_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [ADDR_W-1:0] z_addr_o,
  output logic              first_k_o,
  output logic              last_k_o,
  input  logic              store_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       stall_cnt_o
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0] OMAX = OW'(MAX_OUTST);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e            state_q;
  logic [OW-1:0]     outst_q, outst_nx;
  logic              zero_pend_q;

  logic [CNT_W-1:0]  m_last_q, n_last_q, k_last_q;
  logic [ADDR_W-1:0] w_base_q;
  logic [ADDR_W-1:0] x_m_stride_q, x_k_stride_q, w_k_stride_q;
  logic [ADDR_W-1:0] w_n_stride_q, z_m_stride_q, z_n_stride_q;
  // Per-loop running bases: x at (m,0), w at (0,n), z at (m,0)
  logic [ADDR_W-1:0] x_m_base_q, w_n_base_q, z_m_base_q;

  logic              k_wrap, n_wrap, m_wrap, final_tile;
  logic [CNT_W-1:0]  nxt_m, nxt_n, nxt_k;
  logic [ADDR_W-1:0] nxt_x, nxt_w, nxt_z, nxt_xm, nxt_wn, nxt_zm;
  logic              nxt_last;
  logic              accept, start_ok, cfg_zero, inc, start_last;

  assign accept     = tile_valid_o && tile_ready_i;
  assign start_ok   = (state_q == S_IDLE) && start_i;
  assign cfg_zero   = (m_tiles_i == '0) || (n_tiles_i == '0) || (k_tiles_i == '0);
  assign start_last = (k_tiles_i == CNT_W'(1));
  assign inc        = accept && last_k_o;

  // Simultaneous issue and retire cancel; a retire with nothing outstanding is dropped
  always_comb begin
    outst_nx = outst_q;
    if (inc && store_done_i)              outst_nx = outst_q;
    else if (inc)                         outst_nx = outst_q + OW'(1);
    else if (store_done_i && outst_q != '0) outst_nx = outst_q - OW'(1);
  end

  always_comb begin
    k_wrap     = (tile_k_o == k_last_q);
    n_wrap     = (tile_n_o == n_last_q);
    m_wrap     = (tile_m_o == m_last_q);
    final_tile = k_wrap && n_wrap && m_wrap;
    nxt_m      = tile_m_o;
    nxt_n      = tile_n_o;
    nxt_k      = tile_k_o + CNT_W'(1);
    nxt_x      = x_addr_o + x_k_stride_q;
    nxt_w      = w_addr_o + w_k_stride_q;
    nxt_z      = z_addr_o;
    nxt_xm     = x_m_base_q;
    nxt_wn     = w_n_base_q;
    nxt_zm     = z_m_base_q;
    if (k_wrap) begin
      nxt_k = '0;
      if (!n_wrap) begin
        nxt_n  = tile_n_o + CNT_W'(1);
        nxt_wn = w_n_base_q + w_n_stride_q;
        nxt_x  = x_m_base_q;
        nxt_w  = nxt_wn;
        nxt_z  = z_addr_o + z_n_stride_q;
      end else begin
        nxt_m  = tile_m_o + CNT_W'(1);
        nxt_n  = '0;
        nxt_xm = x_m_base_q + x_m_stride_q;
        nxt_wn = w_base_q;
        nxt_zm = z_m_base_q + z_m_stride_q;
        nxt_x  = nxt_xm;
        nxt_w  = w_base_q;
        nxt_z  = nxt_zm;
      end
    end
    nxt_last = (nxt_k == k_last_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      outst_q      <= '0;
      zero_pend_q  <= 1'b0;
      m_last_q     <= '0;
      n_last_q     <= '0;
      k_last_q     <= '0;
      w_base_q     <= '0;
      x_m_stride_q <= '0;
      x_k_stride_q <= '0;
      w_k_stride_q <= '0;
      w_n_stride_q <= '0;
      z_m_stride_q <= '0;
      z_n_stride_q <= '0;
      x_m_base_q   <= '0;
      w_n_base_q   <= '0;
      z_m_base_q   <= '0;
      tile_valid_o <= 1'b0;
      tile_m_o     <= '0;
      tile_n_o     <= '0;
      tile_k_o     <= '0;
      x_addr_o     <= '0;
      w_addr_o     <= '0;
      z_addr_o     <= '0;
      first_k_o    <= 1'b0;
      last_k_o     <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else if (clear_i) begin
      state_q      <= S_IDLE;
      outst_q      <= '0;
      zero_pend_q  <= 1'b0;
      tile_valid_o <= 1'b0;
      tile_m_o     <= '0;
      tile_n_o     <= '0;
      tile_k_o     <= '0;
      x_addr_o     <= '0;
      w_addr_o     <= '0;
      z_addr_o     <= '0;
      first_k_o    <= 1'b0;
      last_k_o     <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      outst_q <= outst_nx;
      done_o  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            m_last_q     <= m_tiles_i - CNT_W'(1);
            n_last_q     <= n_tiles_i - CNT_W'(1);
            k_last_q     <= k_tiles_i - CNT_W'(1);
            w_base_q     <= w_base_i;
            x_m_stride_q <= x_m_stride_i;
            x_k_stride_q <= x_k_stride_i;
            w_k_stride_q <= w_k_stride_i;
            w_n_stride_q <= w_n_stride_i;
            z_m_stride_q <= z_m_stride_i;
            z_n_stride_q <= z_n_stride_i;
            if (cfg_zero) begin
              // Extra DONE cycle so an empty job reports done two cycles after start
              state_q     <= S_DONE;
              zero_pend_q <= 1'b1;
            end else begin
              state_q      <= S_ISSUE;
              busy_o       <= 1'b1;
              x_m_base_q   <= x_base_i;
              w_n_base_q   <= w_base_i;
              z_m_base_q   <= z_base_i;
              tile_m_o     <= '0;
              tile_n_o     <= '0;
              tile_k_o     <= '0;
              x_addr_o     <= x_base_i;
              w_addr_o     <= w_base_i;
              z_addr_o     <= z_base_i;
              first_k_o    <= 1'b1;
              last_k_o     <= start_last;
              tile_valid_o <= !(start_last && outst_nx == OMAX);
            end
          end
        end
        S_ISSUE: begin
          if (accept) begin
            if (final_tile) begin
              state_q      <= S_DRAIN;
              tile_valid_o <= 1'b0;
            end else begin
              tile_m_o     <= nxt_m;
              tile_n_o     <= nxt_n;
              tile_k_o     <= nxt_k;
              x_addr_o     <= nxt_x;
              w_addr_o     <= nxt_w;
              z_addr_o     <= nxt_z;
              x_m_base_q   <= nxt_xm;
              w_n_base_q   <= nxt_wn;
              z_m_base_q   <= nxt_zm;
              first_k_o    <= (nxt_k == '0);
              last_k_o     <= nxt_last;
              tile_valid_o <= !(nxt_last && outst_nx == OMAX);
            end
          end else if (!tile_valid_o) begin
            tile_valid_o <= !(last_k_o && outst_nx == OMAX);
          end
        end
        S_DRAIN: begin
          if (outst_q == '0) begin
            state_q <= S_DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end
        end
        S_DONE: begin
          if (zero_pend_q) begin
            zero_pend_q <= 1'b0;
            done_o      <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef REDMULE_TILE_SCHED_PERF_EN
  // Every ISSUE cycle without acceptance is a stall, whether from ready or the store limit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
    end else if (clear_i || start_ok) begin
      stall_cnt_o <= '0;
    end else if (state_q == S_ISSUE && !accept && stall_cnt_o != '1) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`else
  assign stall_cnt_o = '0;
`endif

endmodule
